// File: rtl/serial_in_receiver.sv
// Receiver for the two-wire serial link: synchronises SerD/SerC, tracks start/stop,
// shifts in address and data MSB first, drives both ack slots and presents each frame.
module serial_in_receiver #(
  parameter int               sizeA       = 7,
  parameter int               sizeD       = 8,
  parameter logic [sizeA-1:0] OWN_ADDR    = 7'h2A,
  parameter bit               ADDR_FILTER = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             SerD,
  input  logic             SerC,
  output logic             AckOE,
  output logic [sizeA-1:0] A_out,
  output logic [sizeD-1:0] D_out,
  output logic             Valid,
  output logic             Err,
  output logic             Busy
);

  localparam int MAXW = (sizeA > sizeD) ? sizeA : sizeD;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_STOP_WAIT
  } state_t;

  typedef struct packed {
    logic [sizeA-1:0] addr;
    logic [sizeD-1:0] data;
  } frame_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [sizeA-1:0] addr_sh_q, addr_sh_d;
  logic [sizeD-1:0] data_sh_q, data_sh_d;
  frame_t           frame_q, frame_d;
  logic             ackoe_q, ackoe_d;
  logic             ack_rise_q, ack_rise_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic sd_meta_q, sd_q, sd_prev_q;
  logic sc_meta_q, sc_q, sc_prev_q;

  logic sc_rise, sc_fall, sc_high, start_cond, stop_cond;

  // Start/stop only count while SerC is stably high, so a coincident SerC edge wins.
  assign sc_rise    = ~sc_prev_q &  sc_q;
  assign sc_fall    =  sc_prev_q & ~sc_q;
  assign sc_high    =  sc_prev_q &  sc_q;
  assign start_cond = sc_high &  sd_prev_q & ~sd_q;
  assign stop_cond  = sc_high & ~sd_prev_q &  sd_q;

  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      sd_meta_q  <= 1'b1;
      sd_q       <= 1'b1;
      sd_prev_q  <= 1'b1;
      sc_meta_q  <= 1'b1;
      sc_q       <= 1'b1;
      sc_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      frame_q    <= '0;
      ackoe_q    <= 1'b0;
      ack_rise_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sd_meta_q  <= SerD;
      sd_q       <= sd_meta_q;
      sd_prev_q  <= sd_q;
      sc_meta_q  <= SerC;
      sc_q       <= sc_meta_q;
      sc_prev_q  <= sc_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      frame_q    <= frame_d;
      ackoe_q    <= ackoe_d;
      ack_rise_q <= ack_rise_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    frame_d    = frame_q;
    ackoe_d    = ackoe_q;
    ack_rise_d = ack_rise_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (start_cond) begin
      err_d      = (state_q != S_IDLE);
      state_d    = S_ADDR;
      cnt_d      = '0;
      ackoe_d    = 1'b0;
      ack_rise_d = 1'b0;
    end else if (stop_cond && state_q != S_IDLE && state_q != S_STOP_WAIT) begin
      err_d      = 1'b1;
      state_d    = S_IDLE;
      ackoe_d    = 1'b0;
      ack_rise_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (sc_rise) begin
          addr_sh_d = {addr_sh_q[sizeA-2:0], sd_q};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(sizeA - 1)) begin
            cnt_d      = '0;
            ack_rise_d = 1'b0;
            if (ADDR_FILTER && addr_sh_d != OWN_ADDR) state_d = S_IDLE;
            else                                      state_d = S_ACK_A;
          end
        end
        S_ACK_A, S_ACK_D: begin
          // First fall opens the slot, the rise is the ack bit, the next fall closes it.
          if (sc_rise && ackoe_q) ack_rise_d = 1'b1;
          if (sc_fall) begin
            if (!ackoe_q) ackoe_d = 1'b1;
            else if (ack_rise_q) begin
              ackoe_d    = 1'b0;
              ack_rise_d = 1'b0;
              cnt_d      = '0;
              state_d    = (state_q == S_ACK_A) ? S_DATA : S_STOP_WAIT;
            end
          end
        end
        S_DATA: if (sc_rise) begin
          data_sh_d = {data_sh_q[sizeD-2:0], sd_q};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(sizeD - 1)) begin
            cnt_d      = '0;
            ack_rise_d = 1'b0;
            state_d    = S_ACK_D;
          end
        end
        S_STOP_WAIT: begin
          if (stop_cond) begin
            frame_d.addr = addr_sh_q;
            frame_d.data = data_sh_q;
            valid_d      = 1'b1;
            state_d      = S_IDLE;
          end else if (sc_fall) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    AckOE = ackoe_q;
    Valid = valid_q;
    Err   = err_q;
    Busy  = (state_q != S_IDLE);
    A_out = frame_q.addr;
    D_out = frame_q.data;
  end

endmodule

// File: tb/tb_serial_in_receiver.sv
// Directed bench: bit-banged master on an open-drain SerD, one filtering and one
// promiscuous receiver on the same wires.
module tb_serial_in_receiver;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic       sd_m = 1'b1, sc_m = 1'b1;
  wire        ser_d;
  logic       ack_f, ack_nf;
  logic [6:0] a_f, a_nf;
  logic [7:0] d_f, d_nf;
  logic       v_f, v_nf, e_f, e_nf, busy_f, busy_nf;

  int n_chk = 0, n_fail = 0;
  int vcnt = 0, ecnt = 0, vcnt_nf = 0;

  always #5 clk_in = ~clk_in;

  assign ser_d = sd_m & ~ack_f & ~ack_nf;

  serial_in_receiver #(.ADDR_FILTER(1'b1)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .SerD(ser_d), .SerC(sc_m),
    .AckOE(ack_f), .A_out(a_f), .D_out(d_f), .Valid(v_f), .Err(e_f), .Busy(busy_f));

  serial_in_receiver #(.ADDR_FILTER(1'b0)) dut_nf (
    .clk_in(clk_in), .reset_n(reset_n), .SerD(ser_d), .SerC(sc_m),
    .AckOE(ack_nf), .A_out(a_nf), .D_out(d_nf), .Valid(v_nf), .Err(e_nf), .Busy(busy_nf));

  always @(negedge clk_in) begin
    if (v_f)  vcnt    <= vcnt + 1;
    if (e_f)  ecnt    <= ecnt + 1;
    if (v_nf) vcnt_nf <= vcnt_nf + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // SerC = clk_in/8: 4 cycles low (data set up), 4 cycles high.
  task automatic send_bit(input logic b);
    sd_m = b; tick(4); sc_m = 1'b1; tick(4); sc_m = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_c;
    sd_m = 1'b0; tick(4); sc_m = 1'b0;
  endtask

  task automatic stop_c;
    sd_m = 1'b0; tick(4); sc_m = 1'b1; tick(4); sd_m = 1'b1; tick(8);
  endtask

  // Returns {AckOE late in the low phase, AckOE late in the high phase}.
  task automatic ack_slot(output logic [1:0] seen);
    sd_m = 1'b1; tick(4); seen[1] = ack_f;
    sc_m = 1'b1; tick(4); seen[0] = ack_f; sc_m = 1'b0;
  endtask

  task automatic frame(input logic [6:0] a, input logic [7:0] d,
                       output logic [1:0] aa, output logic [1:0] ad, output logic busy_a);
    start_c;
    send_bits({1'b0, a}, 7);
    busy_a = busy_f;
    ack_slot(aa);
    send_bits(d, 8);
    ack_slot(ad);
    stop_c;
  endtask

  task automatic test_reset;
    tick(3);
    n_chk++; if (ack_f !== 1'b0) begin n_fail++; $display("FAIL reset_ackoe: got %b want 0", ack_f); end
    n_chk++; if (a_f !== 7'h00 || d_f !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h/%h want 00/00", a_f, d_f); end
    n_chk++; if ({v_f, e_f, busy_f} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {v_f, e_f, busy_f}); end
    reset_n = 1'b0;
    tick(8);
    n_chk++; if ({busy_f, ack_f} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got %b want 00", {busy_f, ack_f}); end
  endtask

  task automatic test_nominal;
    logic [1:0] aa, ad; logic ba; int v0, e0;
    v0 = vcnt; e0 = ecnt;
    frame(7'h2A, 8'hA5, aa, ad, ba);
    n_chk++; if (aa !== 2'b11) begin n_fail++; $display("FAIL nom_ack_a: got %b want 11", aa); end
    n_chk++; if (ad !== 2'b11) begin n_fail++; $display("FAIL nom_ack_d: got %b want 11", ad); end
    n_chk++; if (ba !== 1'b1) begin n_fail++; $display("FAIL nom_busy_mid: got %b want 1", ba); end
    n_chk++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL nom_valid_cycles: got %0d want 1", vcnt - v0); end
    n_chk++; if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL nom_err: got %0d want 0", ecnt - e0); end
    n_chk++; if (a_f !== 7'h2A || d_f !== 8'hA5) begin n_fail++; $display("FAIL nom_data: got %h/%h want 2a/a5", a_f, d_f); end
    n_chk++; if (busy_f !== 1'b0) begin n_fail++; $display("FAIL nom_busy_end: got %b want 0", busy_f); end
  endtask

  task automatic test_filter;
    logic [1:0] aa, ad; logic ba; int v0, e0, vn0;
    v0 = vcnt; e0 = ecnt; vn0 = vcnt_nf;
    frame(7'h15, 8'h77, aa, ad, ba);
    n_chk++; if ({aa, ad} !== 4'b0000) begin n_fail++; $display("FAIL flt_no_ack: got %b want 0000", {aa, ad}); end
    n_chk++; if (ba !== 1'b0) begin n_fail++; $display("FAIL flt_busy_after_addr: got %b want 0", ba); end
    n_chk++; if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin n_fail++; $display("FAIL flt_pulses: got v%0d e%0d want v0 e0", vcnt - v0, ecnt - e0); end
    n_chk++; if (a_f !== 7'h2A || d_f !== 8'hA5) begin n_fail++; $display("FAIL flt_hold: got %h/%h want 2a/a5", a_f, d_f); end
    n_chk++; if (vcnt_nf - vn0 !== 1) begin n_fail++; $display("FAIL nf_valid: got %0d want 1", vcnt_nf - vn0); end
    n_chk++; if (a_nf !== 7'h15 || d_nf !== 8'h77) begin n_fail++; $display("FAIL nf_data: got %h/%h want 15/77", a_nf, d_nf); end
  endtask

  task automatic test_stop_err;
    logic [1:0] aa, ad; logic ba; int v0, e0;
    v0 = vcnt; e0 = ecnt;
    start_c; send_bits(8'h2A, 7); ack_slot(aa); send_bits(8'h0A, 4); stop_c;
    n_chk++; if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL stop_err_pulse: got %0d want 1", ecnt - e0); end
    n_chk++; if (vcnt - v0 !== 0 || busy_f !== 1'b0) begin n_fail++; $display("FAIL stop_err_state: got v%0d busy%b want v0 busy0", vcnt - v0, busy_f); end
    n_chk++; if (a_f !== 7'h2A || d_f !== 8'hA5) begin n_fail++; $display("FAIL stop_err_hold: got %h/%h want 2a/a5", a_f, d_f); end
    v0 = vcnt;
    frame(7'h2A, 8'h3C, aa, ad, ba);
    n_chk++; if (vcnt - v0 !== 1 || d_f !== 8'h3C) begin n_fail++; $display("FAIL stop_err_recover: got v%0d d%h want v1 d3c", vcnt - v0, d_f); end
  endtask

  task automatic test_rep_start;
    logic [1:0] aa, ad; logic ba; int v0, e0;
    v0 = vcnt; e0 = ecnt;
    start_c; send_bits(8'h2A, 7); ack_slot(aa);
    sd_m = 1'b1; tick(4); sc_m = 1'b1; tick(4);
    frame(7'h2A, 8'hFF, aa, ad, ba);
    n_chk++; if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL rs_err: got %0d want 1", ecnt - e0); end
    n_chk++; if (vcnt - v0 !== 1 || d_f !== 8'hFF) begin n_fail++; $display("FAIL rs_frame: got v%0d d%h want v1 dff", vcnt - v0, d_f); end
    n_chk++; if ({aa, ad} !== 4'b1111) begin n_fail++; $display("FAIL rs_acks: got %b want 1111", {aa, ad}); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] aa, ad; logic ba; int v0;
    start_c; send_bits(8'h2A, 7);
    sd_m = 1'b1; tick(4);
    n_chk++; if (ack_f !== 1'b1) begin n_fail++; $display("FAIL rm_ack_before: got %b want 1", ack_f); end
    reset_n = 1'b1; #1;
    n_chk++; if (ack_f !== 1'b0) begin n_fail++; $display("FAIL rm_ack_release: got %b want 0", ack_f); end
    n_chk++; if (a_f !== 7'h00 || d_f !== 8'h00 || {v_f, e_f, busy_f} !== 3'b000) begin
      n_fail++; $display("FAIL rm_outputs: got %h/%h %b want 00/00 000", a_f, d_f, {v_f, e_f, busy_f}); end
    @(negedge clk_in);
    reset_n = 1'b0; sd_m = 1'b1; sc_m = 1'b1; tick(8);
    v0 = vcnt;
    frame(7'h2A, 8'h01, aa, ad, ba);
    n_chk++; if (vcnt - v0 !== 1 || a_f !== 7'h2A || d_f !== 8'h01) begin
      n_fail++; $display("FAIL rm_next_frame: got v%0d %h/%h want v1 2a/01", vcnt - v0, a_f, d_f); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] aa, ad; logic ba; int v0;
    v0 = vcnt;
    frame(7'h2A, 8'h00, aa, ad, ba);
    n_chk++; if (vcnt - v0 !== 1 || d_f !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got v%0d d%h want v1 d00", vcnt - v0, d_f); end
    frame(7'h2A, 8'hFF, aa, ad, ba);
    n_chk++; if (vcnt - v0 !== 2 || d_f !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got v%0d d%h want v2 dff", vcnt - v0, d_f); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_filter;
    test_stop_err;
    test_rep_start;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
